// File: rtl/if_fetch_buf.sv
// Instruction fetch buffer: fetches pc_i over a req/gnt/rvalid port, queues pc-tagged
// responses and feeds the IF/ID register. Defining IFB_BYPASS_EN lets a response skip an empty FIFO.

module if_fetch_buf_chk #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CNT_W-1:0] count
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH))));
endmodule

module if_fetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_gnt_i,
    input  logic        inst_rvalid_i,
    input  logic [31:0] inst_rdata_i,
    output logic        stallreq_if_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(32'd1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             drop_r;
    logic             drop_s;
    logic [31:0]      addr_q_r;
    logic [31:0]      addr_q_s;
    logic [31:0]      tag_q_r;
    logic [31:0]      tag_q_s;

    logic [31:0]      fifo_pc_r   [DEPTH];
    logic [31:0]      fifo_inst_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;

    logic [31:0]      id_pc_r;
    logic [31:0]      id_inst_r;
    logic             id_valid_r;

    logic             inflight_s;
    logic [CNT_W-1:0] slots_s;
    logic             can_issue_s;
    logic             req_s;
    logic [31:0]      addr_s;
    logic             rsp_ok_s;
    logic             fifo_empty_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic             unused_stall_s;

    assign unused_stall_s = ^{stall[5:3], stall[0]};

    // Capacity accounting: the outstanding fetch reserves a slot unless it will be dropped
    always_comb begin
        inflight_s   = (state_r == WAIT_RESP) && !drop_r;
        slots_s      = count_r + {{(CNT_W-1){1'b0}}, inflight_s};
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        can_issue_s  = ce_i && !flush && (slots_s < DEPTH_C) &&
                       ((state_r == IDLE) || ((state_r == WAIT_RESP) && inst_rvalid_i));
        rsp_ok_s     = (state_r == WAIT_RESP) && inst_rvalid_i && !drop_r && !flush;
    end

    // Response routing: straight into the IF/ID register or through the FIFO
    always_comb begin
`ifdef IFB_BYPASS_EN
        bypass_s = rsp_ok_s && fifo_empty_s && !stall[1];
`else
        bypass_s = 1'b0;
`endif
        push_s = rsp_ok_s && !bypass_s;
        pop_s  = !flush && !stall[1] && !fifo_empty_s;
    end

    // Fetch FSM next state, request outputs and drop tracking
    always_comb begin
        state_s  = state_r;
        drop_s   = drop_r;
        addr_q_s = addr_q_r;
        tag_q_s  = tag_q_r;
        req_s    = 1'b0;
        addr_s   = pc_i;
        case (state_r)
            IDLE, WAIT_RESP: begin
                req_s  = can_issue_s;
                addr_s = pc_i;
                if (can_issue_s && inst_gnt_i) begin
                    state_s = WAIT_RESP;
                    tag_q_s = pc_i;
                end else if (can_issue_s) begin
                    state_s  = WAIT_GNT;
                    addr_q_s = pc_i;
                end else if ((state_r == WAIT_RESP) && inst_rvalid_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT_GNT: begin
                // Address stays frozen until the memory grants, even across a flush
                req_s  = 1'b1;
                addr_s = addr_q_r;
                if (inst_gnt_i) begin
                    state_s = WAIT_RESP;
                    tag_q_s = addr_q_r;
                end else begin
                    state_s = WAIT_GNT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (flush && ((state_r == WAIT_GNT) || ((state_r == WAIT_RESP) && !inst_rvalid_i))) begin
            drop_s = 1'b1;
        end else if ((state_r == WAIT_RESP) && inst_rvalid_i) begin
            drop_s = 1'b0;
        end else begin
            drop_s = drop_r;
        end
    end

    // FIFO occupancy next value
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    assign inst_req_o    = req_s;
    assign inst_addr_o   = addr_s;
    assign stallreq_if_o = ce_i && !(req_s && inst_gnt_i);

    // Fetch FSM state and request bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            drop_r   <= 1'b0;
            addr_q_r <= 32'h0000_0000;
            tag_q_r  <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            drop_r   <= drop_s;
            addr_q_r <= addr_q_s;
            tag_q_r  <= tag_q_s;
        end
    end

    // FIFO pointers and count; a flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
        end
    end

    // FIFO storage: pc tag alongside the returned instruction word
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= tag_q_r;
            fifo_inst_r[wr_ptr_r] <= inst_rdata_i;
        end
    end

    // IF/ID output register with flush/stall priority
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (stall[1] && !stall[2]) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (stall[1]) begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= id_inst_r;
            id_valid_r <= id_valid_r;
        end else if (!fifo_empty_s) begin
            id_pc_r    <= fifo_pc_r[rd_ptr_r];
            id_inst_r  <= fifo_inst_r[rd_ptr_r];
            id_valid_r <= 1'b1;
        end else if (bypass_s) begin
            id_pc_r    <= tag_q_r;
            id_inst_r  <= inst_rdata_i;
            id_valid_r <= 1'b1;
        end else begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end
    end

    assign id_pc_o    = id_pc_r;
    assign id_inst_o  = id_inst_r;
    assign id_valid_o = id_valid_r;

    if_fetch_buf_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .count (count_r)
    );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: zero-wait memory model, pc_reg model and an in-order
// scoreboard on id_*, plus hand-computed checks for grant delay, fill, flush, bubble and reset.

module tb_if_fetch_buf;
    localparam logic [31:0] MASK = 32'hFFFF_0000;
`ifdef IFB_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic [5:0]  stall = 6'b000000;
    logic        flush = 1'b0;
    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic [31:0] new_pc = 32'h0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] exp_pc = 32'h0;

    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_gnt_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;
    logic        stallreq_if_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign inst_gnt_i    = inst_req_o & gnt_en;
    assign inst_rvalid_i = pend & rv_en;
    assign inst_rdata_i  = paddr ^ MASK;

    if_fetch_buf dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .stall         (stall),
        .flush         (flush),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_gnt_i    (inst_gnt_i),
        .inst_rvalid_i (inst_rvalid_i),
        .inst_rdata_i  (inst_rdata_i),
        .stallreq_if_o (stallreq_if_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: advance pc/memory models, then score any newly loaded ID slot
    task automatic tick();
        logic [31:0] nxt_pc;
        logic        nxt_pend;
        logic [31:0] nxt_paddr;
        logic        held;
        logic        was_rst;
        logic        was_flush;
        #1;
        was_rst   = rst;
        was_flush = flush;
        held      = stall[1] && stall[2] && !flush && !rst;
        nxt_pc    = pc_i;
        if (rst)                            nxt_pc = 32'h0;
        else if (flush)                     nxt_pc = new_pc;
        else if (ce_i && !stallreq_if_o)    nxt_pc = pc_i + 32'd4;
        nxt_pend  = pend;
        nxt_paddr = paddr;
        if (inst_rvalid_i) nxt_pend = 1'b0;
        if (inst_req_o && inst_gnt_i) begin
            nxt_pend  = 1'b1;
            nxt_paddr = inst_addr_o;
        end
        @(posedge clk);
        #2;
        pc_i  = nxt_pc;
        pend  = nxt_pend;
        paddr = nxt_paddr;
        if (was_rst)        exp_pc = 32'h0;
        else if (was_flush) exp_pc = new_pc;
        if (id_valid_o && !held) begin
            check("sb_pc", id_pc_o, exp_pc);
            check("sb_inst", id_inst_o, exp_pc ^ MASK);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; ce_i = 1'b0; stall = 6'b000000; flush = 1'b0;
        gnt_en = 1'b1; rv_en = 1'b1; new_pc = 32'h0;
        tick();
        tick();
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        check("rst_id_pc", id_pc_o, 32'h0);
        check("rst_id_inst", id_inst_o, 32'h0);
        check("rst_id_valid", 32'(id_valid_o), 32'd0);
        check("rst_req", 32'(inst_req_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_if_o), 32'd0);

        // Streaming with zero-wait memory: exact first-valid latency, then one per cycle
        rst = 1'b0; ce_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("a_req", 32'(inst_req_o), 32'd1);
            check("a_addr", inst_addr_o, 32'(4 * c));
            check("a_stallreq", 32'(stallreq_if_o), 32'd0);
            check("a_valid", 32'(id_valid_o), 32'(c >= LAT));
            if (c == LAT) check("a_first_inst", id_inst_o, 32'hFFFF_0000);
            tick();
        end

        // Grant held off for three cycles on pc 0x10
        do_reset();
        rst = 1'b0; ce_i = 1'b1;
        run(4);
        gnt_en = 1'b0;
        for (int c = 4; c < 7; c++) begin
            #1;
            check("b_req", 32'(inst_req_o), 32'd1);
            check("b_addr", inst_addr_o, 32'h10);
            check("b_stallreq", 32'(stallreq_if_o), 32'd1);
            tick();
        end
        gnt_en = 1'b1;
        #1;
        check("b_gnt_addr", inst_addr_o, 32'h10);
        check("b_gnt_stallreq", 32'(stallreq_if_o), 32'd0);
        tick();
        #1;
        check("b_next_addr", inst_addr_o, 32'h14);
        run(6);

        // Hold IF/ID and ID for five cycles: FIFO fills, fetch stops, then drains in order
        do_reset();
        rst = 1'b0; ce_i = 1'b1;
        run(6);
        stall = 6'b000110;
        for (int c = 6; c < 11; c++) begin
            #1;
            if (c >= 9) begin
                check("c_full_req", 32'(inst_req_o), 32'd0);
                check("c_full_stallreq", 32'(stallreq_if_o), 32'd1);
                check("c_hold_pc", id_pc_o, 32'(4 * (6 - LAT)));
                check("c_hold_valid", 32'(id_valid_o), 32'd1);
            end
            tick();
        end
        stall = 6'b000000;
        #1;
        check("c_rel_req", 32'(inst_req_o), 32'd0);
        check("c_rel_stallreq", 32'(stallreq_if_o), 32'd1);
        tick();
        run(9);
        #1;
        check("c_drain_pc", id_pc_o, 32'(4 * (21 - LAT - 5)));

        // Flush while waiting on the response for 0x20; restart at 0x180
        do_reset();
        rst = 1'b0; ce_i = 1'b1;
        run(9);
        flush = 1'b1; rv_en = 1'b0; new_pc = 32'h180;
        #1;
        check("d_flush_req", 32'(inst_req_o), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("d_wait_req", 32'(inst_req_o), 32'd0);
        check("d_wait_stallreq", 32'(stallreq_if_o), 32'd1);
        check("d_wait_valid", 32'(id_valid_o), 32'd0);
        tick();
        rv_en = 1'b1;
        #1;
        check("d_new_req", 32'(inst_req_o), 32'd1);
        check("d_new_addr", inst_addr_o, 32'h180);
        check("d_drop_valid", 32'(id_valid_o), 32'd0);
        tick();
        #1;
        check("d_gap_valid", 32'(id_valid_o), 32'd0);
        run(LAT - 1);
        #1;
        check("d_first_pc", id_pc_o, 32'h180);
        check("d_first_valid", 32'(id_valid_o), 32'd1);
        run(3);

        // IF/ID stalled with ID running: bubble, then 0x40 delivered
        do_reset();
        rst = 1'b0; ce_i = 1'b1;
        run(15 + LAT);
        stall = 6'b000010;
        run(4 - LAT);
        stall = 6'b000000;
        #1;
        check("e_bub_pc", id_pc_o, 32'h0);
        check("e_bub_inst", id_inst_o, 32'h0);
        check("e_bub_valid", 32'(id_valid_o), 32'd0);
        tick();
        #1;
        check("e_pc", id_pc_o, 32'h40);
        check("e_inst", id_inst_o, 32'h40 ^ MASK);
        check("e_valid", 32'(id_valid_o), 32'd1);
        run(3);

        // Reset in WAIT_RESP; the late response must never reach ID
        do_reset();
        rst = 1'b0; ce_i = 1'b1;
        run(4);
        rst = 1'b1; rv_en = 1'b0;
        tick();
        rst = 1'b0; ce_i = 1'b0; rv_en = 1'b1;
        #1;
        check("f_id_pc", id_pc_o, 32'h0);
        check("f_id_inst", id_inst_o, 32'h0);
        check("f_id_valid", 32'(id_valid_o), 32'd0);
        check("f_req", 32'(inst_req_o), 32'd0);
        check("f_stallreq", 32'(stallreq_if_o), 32'd0);
        tick();
        #1;
        check("f_late_valid", 32'(id_valid_o), 32'd0);
        tick();
        ce_i = 1'b1;
        #1;
        check("f_restart_req", 32'(inst_req_o), 32'd1);
        check("f_restart_addr", inst_addr_o, 32'h0);
        tick();
        run(LAT - 1);
        #1;
        check("f_first_pc", id_pc_o, 32'h0);
        check("f_first_inst", id_inst_o, 32'hFFFF_0000);
        check("f_first_valid", 32'(id_valid_o), 32'd1);
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
